// File: rtl/axi_write_arbiter_if.sv
// AXI-lite write channels (AW/W/B) between the arbiter and its single slave.
interface axi_write_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic                    BRESP;
    logic                    BVALID;
    logic                    BREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/axi_write_arbiter.sv
// Two-requester round-robin front end for a single AXI-lite write slave.
// One write in flight; illegal addresses are answered locally with an error.
module axi_write_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_LIMIT    = 16,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      req0_valid,
    input  logic [ADDR_WIDTH-1:0]     req0_addr,
    input  logic [DATA_WIDTH-1:0]     req0_data,
    input  logic [DATA_WIDTH/8-1:0]   req0_strb,
    output logic                      req0_ready,
    output logic                      req0_done,
    output logic                      req0_resp,
    input  logic                      req1_valid,
    input  logic [ADDR_WIDTH-1:0]     req1_addr,
    input  logic [DATA_WIDTH-1:0]     req1_data,
    input  logic [DATA_WIDTH/8-1:0]   req1_strb,
    output logic                      req1_ready,
    output logic                      req1_done,
    output logic                      req1_resp,
    axi_write_arbiter_if.master       axi,
    output logic                      busy,
    output logic [ERR_CNT_WIDTH-1:0]  err_count
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(ADDR_LIMIT - STRB_WIDTH);

    typedef enum logic [1:0] {IDLE, XFER, RESP, REJECT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
    } req_t;

    state_t     state, state_nxt;
    req_t [1:0] req;
    req_t       win_req;
    logic [1:0] req_valid, ready, done_q, resp_q;
    logic       prio, win_id, lat_id;
    logic       accept, legal, aw_done, w_done, err_inc;

    assign req_valid = {req1_valid, req0_valid};
    assign req[0]    = {req0_addr, req0_data, req0_strb};
    assign req[1]    = {req1_addr, req1_data, req1_strb};

    // Contention is settled by prio; a lone requester always wins.
    assign win_id  = (&req_valid) ? prio : req_valid[1];
    assign win_req = req[win_id];
    assign accept  = (state == IDLE) && (|req_valid);
    assign legal   = (win_req.addr <= MAX_ADDR);
    assign ready   = accept ? (win_id ? 2'b10 : 2'b01) : 2'b00;

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_resp  = resp_q[0];
    assign req1_resp  = resp_q[1];
    assign busy       = (state != IDLE);

    // A channel counts as finished if already idle or handshaking this edge.
    assign aw_done = !axi.AWVALID || axi.AWREADY;
    assign w_done  = !axi.WVALID  || axi.WREADY;
    assign err_inc = (state == REJECT) || (state == RESP && axi.BVALID && axi.BRESP);

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept) state_nxt = legal ? XFER : REJECT;
            XFER:   if (aw_done && w_done) state_nxt = RESP;
            RESP:   if (axi.BVALID) state_nxt = IDLE;
            REJECT: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            prio        <= 1'b0;
            lat_id      <= 1'b0;
            axi.AWADDR  <= '0;
            axi.AWVALID <= 1'b0;
            axi.WDATA   <= '0;
            axi.WSTRB   <= '0;
            axi.WVALID  <= 1'b0;
            axi.BREADY  <= 1'b0;
            done_q      <= '0;
            resp_q      <= '0;
            err_count   <= '0;
        end else begin
            done_q <= '0;
            resp_q <= '0;
            case (state)
                IDLE: if (accept) begin
                    lat_id <= win_id;
                    prio   <= ~win_id;
                    if (legal) begin
                        axi.AWADDR  <= win_req.addr;
                        axi.WDATA   <= win_req.data;
                        axi.WSTRB   <= win_req.strb;
                        axi.AWVALID <= 1'b1;
                        axi.WVALID  <= 1'b1;
                    end
                end
                XFER: begin
                    if (axi.AWVALID && axi.AWREADY) axi.AWVALID <= 1'b0;
                    if (axi.WVALID && axi.WREADY)   axi.WVALID  <= 1'b0;
                    if (aw_done && w_done)          axi.BREADY  <= 1'b1;
                end
                RESP: if (axi.BVALID) begin
                    axi.BREADY     <= 1'b0;
                    done_q[lat_id] <= 1'b1;
                    resp_q[lat_id] <= axi.BRESP;
                end
                REJECT: begin
                    done_q[lat_id] <= 1'b1;
                    resp_q[lat_id] <= 1'b1;
                end
            endcase
            if (err_inc && err_count != '1)
                err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: AXI-lite slave with programmable stalls and a
// transaction-level model predicting grants, channel activity and completions.
module tb_axi_write_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr, req0_data, req1_data;
    logic [3:0]  req0_strb, req1_strb;
    logic        req0_ready, req0_done, req0_resp;
    logic        req1_ready, req1_done, req1_resp;
    logic        busy;
    logic [7:0]  err_count;

    axi_write_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi();

    axi_write_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_LIMIT(16), .ERR_CNT_WIDTH(8)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_strb(req0_strb), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_resp(req0_resp),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_strb(req1_strb), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_resp(req1_resp),
        .axi(axi), .busy(busy), .err_count(err_count)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- slave with stall knobs ----------------
    int          aw_stall = 0, w_stall = 0, b_stall = 0;
    logic        force_bresp = 1'b0, stray_b = 1'b0;
    int          aw_wait, w_wait, b_wait;
    logic        aw_have, w_have, bv;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_strb;
    logic [7:0]  s_mem [16];

    assign axi.AWREADY = axi.AWVALID && !aw_have && (aw_wait >= aw_stall);
    assign axi.WREADY  = axi.WVALID && !w_have && (w_wait >= w_stall);
    assign axi.BVALID  = bv || stray_b;
    assign axi.BRESP   = force_bresp;

    always @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0;
            aw_have <= 1'b0; w_have <= 1'b0; bv <= 1'b0;
            for (int i = 0; i < 16; i++) s_mem[i] <= 8'h00;
        end else begin
            if (axi.AWREADY) begin aw_have <= 1'b1; s_addr <= axi.AWADDR; aw_wait <= 0; end
            else if (axi.AWVALID) aw_wait <= aw_wait + 1;
            if (axi.WREADY) begin w_have <= 1'b1; s_data <= axi.WDATA; s_strb <= axi.WSTRB; w_wait <= 0; end
            else if (axi.WVALID) w_wait <= w_wait + 1;
            if (aw_have && w_have && !bv) begin
                if (b_wait >= b_stall) begin
                    bv <= 1'b1; b_wait <= 0;
                    for (int i = 0; i < 4; i++)
                        if (s_strb[i]) s_mem[4'(s_addr[3:0] + 4'(i))] <= s_data[8*i +: 8];
                end else b_wait <= b_wait + 1;
            end
            if (bv && axi.BREADY) begin bv <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0; end
        end
    end

    // ---------------- requester drive + reference model ----------------
    int          errors = 0, checks = 0, cyc = 0;
    bit          r_pend [2], acc_prev [2], rearm;
    logic [31:0] r_addr [2], r_data [2];
    logic [3:0]  r_strb [2];
    int          d_aws = 0, d_ws = 0, d_bs = 0;
    bit          d_bresp = 0;
    bit          m_act, m_id, m_legal, m_resp, m_prio, m_bresp;
    int          m_acc, m_done, m_aws, m_ws, m_bs, m_err;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_strb;
    logic [7:0]  m_mem [16];
    bit          gq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = r_pend[0]; req0_addr = r_addr[0]; req0_data = r_data[0]; req0_strb = r_strb[0];
        req1_valid = r_pend[1]; req1_addr = r_addr[1]; req1_data = r_data[1]; req1_strb = r_strb[1];
    endtask

    // One clock: called and returns at a falling edge.
    task automatic step(input bit rnd);
        bit fin, any, win, exp_aw, exp_w, exp_b;
        int mx;
        fin = m_act && (cyc == m_done);
        if (fin) begin
            if (m_resp && m_err < 255) m_err++;
            if (m_legal)
                for (int i = 0; i < 4; i++)
                    if (m_strb[i]) m_mem[4'(m_addr[3:0] + 4'(i))] = m_data[8*i +: 8];
        end
        mx     = (m_aws > m_ws) ? m_aws : m_ws;
        exp_aw = m_act && m_legal && (cyc <= m_acc + m_aws);
        exp_w  = m_act && m_legal && (cyc <= m_acc + m_ws);
        exp_b  = m_act && m_legal && (cyc >= m_acc + 1 + mx) && (cyc < m_done);
        chk("busy", busy, m_act && !fin);
        chk("req0_done", req0_done, fin && !m_id);
        chk("req1_done", req1_done, fin && m_id);
        if (fin) chk("resp", m_id ? req1_resp : req0_resp, m_resp);
        chk("AWVALID", axi.AWVALID, exp_aw);
        chk("WVALID", axi.WVALID, exp_w);
        chk("BREADY", axi.BREADY, exp_b);
        if (exp_aw) chk("AWADDR", axi.AWADDR, m_addr);
        if (exp_w) begin chk("WDATA", axi.WDATA, m_data); chk("WSTRB", axi.WSTRB, m_strb); end
        chk("err_count", err_count, m_err);
        if (fin) m_act = 0;

        for (int n = 0; n < 2; n++) begin
            if (acc_prev[n]) begin acc_prev[n] = 0; r_pend[n] = rearm; end
            if (rnd && !r_pend[n] && $urandom_range(0, 2) == 0) begin
                r_pend[n] = 1;
                case ($urandom_range(0, 5))
                    0:       r_addr[n] = $urandom_range(13, 40);
                    1:       r_addr[n] = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                    default: r_addr[n] = $urandom_range(0, 12);
                endcase
                r_data[n] = $urandom;
                r_strb[n] = 4'($urandom);
            end
        end
        drive();
        #1;
        any = r_pend[0] || r_pend[1];
        win = (r_pend[0] && r_pend[1]) ? m_prio : r_pend[1];
        chk("req0_ready", req0_ready, !m_act && any && !win);
        chk("req1_ready", req1_ready, !m_act && any && win);
        if (req0_ready) gq.push_back(1'b0);
        if (req1_ready) gq.push_back(1'b1);
        if (!m_act && any) begin
            m_act = 1; m_id = win; m_acc = cyc + 1;
            m_addr = r_addr[win]; m_data = r_data[win]; m_strb = r_strb[win];
            m_legal = (r_addr[win] <= 32'd12);
            if (rnd) begin
                m_aws = $urandom_range(0, 3); m_ws = $urandom_range(0, 3);
                m_bs = $urandom_range(0, 2);  m_bresp = ($urandom_range(0, 3) == 0);
            end else begin
                m_aws = d_aws; m_ws = d_ws; m_bs = d_bs; m_bresp = d_bresp;
            end
            aw_stall = m_aws; w_stall = m_ws; b_stall = m_bs; force_bresp = m_bresp;
            m_resp = !m_legal || m_bresp;
            m_done = m_acc + (m_legal ? 3 + ((m_aws > m_ws) ? m_aws : m_ws) + m_bs : 1);
            m_prio = !win;
            acc_prev[win] = 1;
        end
        @(posedge ACLK); cyc++;
        @(negedge ACLK);
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((m_act || r_pend[0] || r_pend[1]) && n < budget) begin step(0); n++; end
        chk("idle_within_budget", m_act || r_pend[0] || r_pend[1], 0);
    endtask

    task automatic do_reset();
        for (int n = 0; n < 2; n++) begin r_pend[n] = 0; acc_prev[n] = 0; end
        drive();
        ARESET = 1'b0;
        #1;
        chk("rst_ctrl", {axi.AWVALID, axi.WVALID, axi.BREADY, busy,
                         req0_done, req1_done, req0_resp, req1_resp}, 0);
        chk("rst_awaddr", axi.AWADDR, 0);
        chk("rst_wdata_strb", {axi.WDATA, axi.WSTRB}, 0);
        chk("rst_err", err_count, 0);
        m_act = 0; m_prio = 0; m_err = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        repeat (2) begin @(posedge ACLK); cyc++; end
        @(negedge ACLK);
        ARESET = 1'b1;
    endtask

    task automatic req(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        r_pend[n] = 1; r_addr[n] = a; r_data[n] = d; r_strb[n] = s;
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin r_addr[n] = 0; r_data[n] = 0; r_strb[n] = 0; end
        rearm = 0;
        do_reset();

        // single legal write from requester 0, slave ready at once
        req(0, 32'h4, 32'hA1B2C3D4, 4'hF);
        run_idle(20);
        chk("mem_4_7", {s_mem[7], s_mem[6], s_mem[5], s_mem[4]}, 32'hA1B2C3D4);
        chk("err_after_ok", err_count, 0);

        // out-of-range address rejected locally
        req(1, 32'hD, 32'h11223344, 4'hF);
        run_idle(10);
        chk("err_after_reject", err_count, 1);

        // stray BVALID while idle must be ignored
        stray_b = 1'b1; step(0); step(0); stray_b = 1'b0;

        // both requesters held valid: grants alternate
        gq.delete();
        rearm = 1;
        req(0, 32'h0, 32'h0A0A0A0A, 4'hF);
        req(1, 32'hC, 32'h0B0B0B0B, 4'h3);
        for (int i = 0; i < 60 && gq.size() < 4; i++) step(0);
        rearm = 0;
        for (int n = 0; n < 2; n++) begin r_pend[n] = 0; acc_prev[n] = 0; end
        run_idle(20);
        chk("grant_count", gq.size(), 4);
        if (gq.size() >= 4) chk("grant_seq", {gq[0], gq[1], gq[2], gq[3]}, 4'b0101);

        // AWREADY stalled 3 cycles, WREADY immediate, then slow B
        d_aws = 3; d_ws = 0; d_bs = 2;
        req(0, 32'h8, 32'hCAFEF00D, 4'hF);
        run_idle(30);
        d_aws = 0; d_bs = 0;

        // slave error responses, including saturation
        d_bresp = 1;
        for (int i = 0; i < 260; i++) begin
            req(i % 2, 32'h4, 32'h0, 4'h0);
            run_idle(20);
        end
        d_bresp = 0;
        chk("err_saturated", err_count, 8'hFF);

        // reset during XFER with AWVALID held by a stalled slave
        d_aws = 5;
        req(0, 32'h0, 32'h55AA55AA, 4'hF);
        step(0); step(0); step(0);
        chk("pre_reset_awvalid", axi.AWVALID, 1);
        do_reset();
        d_aws = 0;
        gq.delete();
        req(0, 32'h0, 32'h12345678, 4'hF);
        req(1, 32'h4, 32'h9ABCDEF0, 4'hF);
        step(0);
        chk("post_reset_first_grant", (gq.size() == 1) ? gq[0] : 1'bx, 0);
        run_idle(30);
        chk("post_reset_mem0", {s_mem[3], s_mem[2], s_mem[1], s_mem[0]}, 32'h12345678);

        // randomized traffic and slave timing
        for (int i = 0; i < 600; i++) step(1);
        run_idle(60);
        for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), s_mem[i], m_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
